latex_stream_engine: RTL and testbench
======================================

// Module: latex_stream_engine
// PURPOSE
//  Parametrised successor to the transform sequencer. Given a line index and a start
//  edge, it looks up {base,len} in a pointer table, reads packed {lhs,rhs} char pairs
//  from char memory, and presents them on a valid/ready stream. Adds backpressure,
//  loop mode, abort, a range check and a done pulse. Sits between the top-level
//  switch inputs, line_mapper and memory_chars, and drives the uio_out/uo_out chars.
// PARAMETERS
//  LINE_W    6     width of line index
//  NUM_LINES 51    valid lines are 0..NUM_LINES-1
//  ADDR_W    10    char-memory address width; also the width of len and chars_remaining
//  CHAR_W    8     bits per char (ASCII)
//  IDLE_CHAR 8'h20 value of lhs/rhs when not streaming
// PORTS
//  clk             in   1          single clock
//  rst             in   1          synchronous, active-high reset
//  start           in   1          rising edge (start & ~start_q) launches a line
//  abort           in   1          synchronous abort to IDLE
//  loop            in   1          sampled in DONE: 1 = replay the line from base
//  line            in   LINE_W     line index; latched on the start edge
//  ptr_line        out  LINE_W     pointer-table index
//  ptr_data        in   2*ADDR_W   {base,len}; valid 1 cycle after ptr_line driven
//  mem_en          out  1          char-memory read strobe
//  mem_addr        out  ADDR_W     char-memory word address
//  mem_dout        in   2*CHAR_W   {lhs,rhs}; valid the cycle after mem_en
//  lhs, rhs        out  CHAR_W     current char pair
//  out_valid       out  1          pair on lhs/rhs is valid
//  out_ready       in   1          consumer accepts when out_valid & out_ready
//  done            out  1          1-cycle pulse after the last pair is accepted
//  busy            out  1          state != IDLE
//  line_err        out  1          sticky: last start had line >= NUM_LINES
//  chars_remaining out  ADDR_W     pairs not yet accepted
//  which_state     out  3          IDLE=0 LOOKUP=1 FETCH=2 WAIT=3 EMIT=4 DONE=5
// BEHAVIOUR
//  Reset: state IDLE; lhs=rhs=IDLE_CHAR; out_valid=done=mem_en=line_err=0;
//   chars_remaining=0; mem_addr=0; ptr_line=0; start_q=0.
//  IDLE: on start edge, latch line. If line>=NUM_LINES, set line_err and stay in IDLE;
//   otherwise clear line_err and go to LOOKUP.
//  LOOKUP: 2 cycles. Cycle 1 drives ptr_line. Cycle 2 captures base, len; sets
//   chars_remaining=len and idx=0. If len==0 go to DONE, else go to FETCH.
//  FETCH: 1 cycle. mem_en=1, mem_addr=(base+idx) mod 2**ADDR_W, so addresses wrap.
//  WAIT: 1 cycle. Register mem_dout into {lhs,rhs}; go to EMIT.
//  EMIT: out_valid=1. lhs/rhs stay stable until accepted. On accept: idx++,
//   chars_remaining--, out_valid=0 next cycle; if chars_remaining was 1 go to DONE,
//   else go to FETCH.
//  DONE: 1 cycle with done=1. If loop=1: idx=0, chars_remaining=len, go to FETCH
//   (no re-lookup). If loop=0: go to IDLE.
//  Timing with out_ready=1: start high in cycle 0 gives first out_valid in cycle 5.
//   One pair every 3 cycles after that.
//  lhs/rhs keep the last pair until a new pair loads or the block returns to IDLE.
//   On entry to IDLE they become IDLE_CHAR.
//  abort=1 in any state: IDLE next cycle; out_valid=0, mem_en=0, chars_remaining=0,
//   lhs/rhs=IDLE_CHAR, no done pulse. abort and start together: abort wins.
//  A start edge while busy is ignored. start_q tracks start in every state, so a start
//   held high across IDLE re-entry does not relaunch.
//  rst mid-operation has the same effect as the reset values above.
// TESTING
//  Reset: assert rst for 2 cycles -> all outputs at reset values; which_state=0,
//   lhs=rhs=8'h20.
//  Normal run: line=3, ptr {0x010,3}, mem[0x10..0x12]={"s1","t2","e3"}, ready=1
//   -> out_valid in cycles 5, 8, 11 with pairs in order; done in cycle 12; IDLE in 13.
//  Backpressure: same setup, ready=0 for 4 cycles in first EMIT -> pair "s1" held
//   stable, chars_remaining=3 throughout; accepted on ready; sequence intact.
//  Edge cases: len=0 -> no out_valid, done 1 cycle after LOOKUP. line=60 -> line_err=1,
//   busy stays 0.
//  Wrap and loop: base=0x3FE, len=4, loop=1 -> mem_addr 3FE,3FF,000,001, then a
//   replay from 3FE after done.
//  Abort: abort in cycle 9 of the normal run -> IDLE in cycle 10, out_valid=0,
//   chars_remaining=0, no done pulse.

Source files
------------

// File: rtl/latex_stream_engine.sv
// latex_stream_engine: looks up {base,len} for a line and streams its packed char pairs over valid/ready
module latex_stream_engine #(
    parameter int LINE_W = 6,
    parameter int NUM_LINES = 51,
    parameter int ADDR_W = 10,
    parameter int CHAR_W = 8,
    parameter logic [CHAR_W-1:0] IDLE_CHAR = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  loop,
    input  logic [LINE_W-1:0]     line,
    output logic [LINE_W-1:0]     ptr_line,
    input  logic [2*ADDR_W-1:0]   ptr_data,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [2*CHAR_W-1:0]   mem_dout,
    output logic [CHAR_W-1:0]     lhs,
    output logic [CHAR_W-1:0]     rhs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  busy,
    output logic                  line_err,
    output logic [ADDR_W-1:0]     chars_remaining,
    output logic [2:0]            which_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOOK1 = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5,
        S_LOOK2 = 3'd6
    } state_t;

    state_t state, next;
    logic start_q;
    logic [ADDR_W-1:0] base, len, idx, p_base, p_len;
    logic start_edge, line_ok, accept;

    assign {p_base, p_len} = ptr_data;
    assign start_edge = start & ~start_q;
    assign line_ok = 32'(line) < NUM_LINES;
    assign accept = out_valid & out_ready;
    assign mem_en = state == S_FETCH;
    assign mem_addr = base + idx;
    assign out_valid = state == S_EMIT;
    assign done = state == S_DONE;
    assign busy = state != S_IDLE;
    // Both lookup phases report as LOOKUP
    assign which_state = state == S_LOOK2 ? 3'd1 : state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = start_edge && line_ok ? S_LOOK1 : S_IDLE;
            S_LOOK1: next = S_LOOK2;
            S_LOOK2: next = p_len == '0 ? S_DONE : S_FETCH;
            S_FETCH: next = S_WAIT;
            S_WAIT:  next = S_EMIT;
            S_EMIT:  next = !accept ? S_EMIT : chars_remaining == ADDR_W'(1) ? S_DONE : S_FETCH;
            S_DONE:  next = loop ? S_FETCH : S_IDLE;
            default: next = S_IDLE;
        endcase
        if (abort) next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            ptr_line <= '0;
            line_err <= 1'b0;
            base <= '0;
            len <= '0;
            idx <= '0;
            chars_remaining <= '0;
            lhs <= IDLE_CHAR;
            rhs <= IDLE_CHAR;
        end else begin
            start_q <= start;
            if (state == S_IDLE && start_edge && !abort) begin
                ptr_line <= line;
                line_err <= !line_ok;
            end
            if (state == S_LOOK2) begin
                base <= p_base;
                len <= p_len;
                chars_remaining <= p_len;
                idx <= '0;
            end
            if (state == S_WAIT) {lhs, rhs} <= mem_dout;
            if (state == S_EMIT && accept) begin
                idx <= idx + 1'b1;
                chars_remaining <= chars_remaining - 1'b1;
            end
            if (state == S_DONE && loop) begin
                idx <= '0;
                chars_remaining <= len;
            end
            // Any return to IDLE (normal, abort) blanks the outputs
            if (next == S_IDLE) begin
                chars_remaining <= '0;
                lhs <= IDLE_CHAR;
                rhs <= IDLE_CHAR;
            end
        end
    end
endmodule

// File: tb/tb_latex_stream_engine.sv
// tb_latex_stream_engine: directed runs against a pointer/char-memory model and a per-cycle stream scoreboard
module tb_latex_stream_engine;
    logic clk, rst, start, abort, loop, out_ready;
    logic [5:0] line, ptr_line;
    logic [19:0] ptr_data;
    logic mem_en, out_valid, done, busy, line_err;
    logic [9:0] mem_addr, chars_remaining;
    logic [15:0] mem_dout;
    logic [7:0] lhs, rhs;
    logic [2:0] which_state;

    latex_stream_engine dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop), .line(line),
        .ptr_line(ptr_line), .ptr_data(ptr_data), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .lhs(lhs), .rhs(rhs), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .busy(busy), .line_err(line_err), .chars_remaining(chars_remaining),
        .which_state(which_state)
    );

    logic [19:0] ptab [64];
    logic [15:0] mem [1024];
    always @(posedge clk) begin
        ptr_data <= ptab[ptr_line];
        if (mem_en) mem_dout <= mem[mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0, k = 0;
    logic [9:0] sb_base, sb_len;
    logic rv [64], rd [64], re [64], rb [64], rerr [64];
    logic [2:0] rs [64];
    logic [9:0] rcr [64], ra [64];
    logic [15:0] rp [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Stream-level expectation: pair k of a line is mem[base+k], k counts accepts
    task automatic sb_step;
        if (!busy) begin
            k = 0;
            chk("idle_lhs", lhs, 8'h20);
            chk("idle_rhs", rhs, 8'h20);
            chk("idle_valid", out_valid, 0);
            chk("idle_remaining", chars_remaining, 0);
        end
        if (mem_en) chk("fetch_addr", mem_addr, 10'(sb_base + 10'(k)));
        if (out_valid) begin
            chk("pair", {lhs, rhs}, mem[10'(sb_base + 10'(k))]);
            chk("remaining", chars_remaining, sb_len - 10'(k));
            if (out_ready) k++;
        end
        if (done) begin
            chk("done_count", k, 32'(sb_len));
            k = 0;
        end
    endtask

    task automatic tick;
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] ln, input int n, input int rlo, input int rhi,
                       input int ab, input int rs_at, input int lp);
        line = ln;
        {sb_base, sb_len} = ptab[ln];
        for (int i = 0; i < n; i++) begin
            start = i < 2;
            out_ready = !(i >= rlo && i < rhi);
            abort = i == ab;
            rst = i == rs_at;
            loop = i < lp;
            rv[i] = out_valid; rd[i] = done; re[i] = mem_en; rb[i] = busy; rerr[i] = line_err;
            rs[i] = which_state; rcr[i] = chars_remaining; ra[i] = mem_addr; rp[i] = {lhs, rhs};
            tick();
        end
        start = 0; abort = 0; rst = 0; loop = 0; out_ready = 1;
    endtask

    int nv;
    logic [9:0] addrs [8];

    initial begin
        for (int i = 0; i < 64; i++) ptab[i] = {10'h100, 10'd1};
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 3);
        ptab[3] = {10'h010, 10'd3};
        ptab[4] = {10'h020, 10'd0};
        ptab[7] = {10'h3FE, 10'd4};
        mem[10'h010] = "s1"; mem[10'h011] = "t2"; mem[10'h012] = "e3";
        sb_base = 0; sb_len = 0;
        rst = 1; start = 0; abort = 0; loop = 0; out_ready = 1; line = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", which_state, 0);
        chk("rst_lhs", lhs, 8'h20);
        chk("rst_rhs", rhs, 8'h20);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_line_err", line_err, 0);
        chk("rst_remaining", chars_remaining, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ptr_line", ptr_line, 0);
        rst = 0;
        repeat (2) tick();

        run(6'd3, 16, 99, 99, 99, 99, 0);
        nv = 0;
        for (int i = 0; i < 14; i++) nv += int'(rv[i]);
        chk("norm_nvalid", nv, 3);
        chk("norm_state0", rs[0], 0);
        chk("norm_state1", rs[1], 1);
        chk("norm_state2", rs[2], 1);
        chk("norm_v5", rv[5], 1);
        chk("norm_v8", rv[8], 1);
        chk("norm_v11", rv[11], 1);
        chk("norm_p5", rp[5], 16'h7331);
        chk("norm_p8", rp[8], 16'h7432);
        chk("norm_p11", rp[11], 16'h6533);
        chk("norm_cr5", rcr[5], 3);
        chk("norm_cr11", rcr[11], 1);
        chk("norm_done12", rd[12], 1);
        chk("norm_done11", rd[11], 0);
        chk("norm_idle13", rs[13], 0);
        chk("norm_cr13", rcr[13], 0);

        run(6'd60, 6, 99, 99, 99, 99, 0);
        chk("err_flag", line_err, 1);
        nv = 0;
        for (int i = 0; i < 6; i++) nv += int'(rb[i]);
        chk("err_busy", nv, 0);

        run(6'd4, 8, 99, 99, 99, 99, 0);
        chk("len0_err_clear", rerr[2], 0);
        chk("len0_done3", rd[3], 1);
        chk("len0_idle4", rs[4], 0);
        nv = 0;
        for (int i = 0; i < 8; i++) nv += int'(rv[i]);
        chk("len0_nvalid", nv, 0);

        run(6'd3, 20, 5, 9, 99, 99, 0);
        for (int i = 5; i < 10; i++) begin
            chk("bp_valid", rv[i], 1);
            chk("bp_hold", rp[i], 16'h7331);
            chk("bp_cr", rcr[i], 3);
        end
        chk("bp_v12", rv[12], 1);
        chk("bp_v15", rv[15], 1);
        chk("bp_p15", rp[15], 16'h6533);
        chk("bp_done16", rd[16], 1);

        run(6'd7, 32, 99, 99, 99, 99, 20);
        nv = 0;
        for (int i = 0; i < 32; i++)
            if (re[i]) begin
                if (nv < 8) addrs[nv] = ra[i];
                nv++;
            end
        chk("wrap_nfetch", nv, 8);
        chk("wrap_a0", addrs[0], 10'h3FE);
        chk("wrap_a1", addrs[1], 10'h3FF);
        chk("wrap_a2", addrs[2], 10'h000);
        chk("wrap_a3", addrs[3], 10'h001);
        chk("wrap_a4", addrs[4], 10'h3FE);
        chk("wrap_done15", rd[15], 1);
        chk("wrap_replay16", rs[16], 2);
        chk("wrap_cr16", rcr[16], 4);
        chk("wrap_done28", rd[28], 1);
        chk("wrap_idle29", rs[29], 0);

        run(6'd3, 16, 99, 99, 9, 99, 0);
        chk("abort_state9", rs[9], 2);
        chk("abort_idle10", rs[10], 0);
        chk("abort_valid10", rv[10], 0);
        chk("abort_cr10", rcr[10], 0);
        chk("abort_lhs10", rp[10], 16'h2020);
        nv = 0;
        for (int i = 0; i < 16; i++) nv += int'(rd[i]);
        chk("abort_nodone", nv, 0);

        run(6'd3, 10, 99, 99, 99, 6, 0);
        chk("mrst_state7", rs[7], 0);
        chk("mrst_cr7", rcr[7], 0);
        chk("mrst_addr7", ra[7], 0);
        chk("mrst_lhs7", rp[7], 16'h2020);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
